// File: rtl/lat_ram_pkg.sv
// Shared types and sizes for the latency-RAM line initiator.
package lat_ram_pkg;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR      = 3'd2,
    RESP    = 3'd3,
    DRAIN   = 3'd4
  } state_t;
endpackage

// File: rtl/lat_ram_timer.sv
// Read wait counter: cleared while idle, counts while waiting, flags TIMEOUT reached.
module lat_ram_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Count saturates at TIMEOUT so a stalled enable cannot wrap back past it.
  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable && (cnt != CW'(TIMEOUT)))
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(TIMEOUT));
endmodule

// File: rtl/lat_ram_initiator.sv
// Single-outstanding line initiator toward a RAM with two-cycle read latency and read timeout.
module lat_ram_initiator
  import lat_ram_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  input  logic                            req_write,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic [LINE_WORDS*BIT_WIDTH-1:0] req_wdata,
  output logic                            req_ready,
  output logic                            resp_valid,
  output logic                            resp_err,
  output logic [LINE_WORDS*BIT_WIDTH-1:0] resp_rdata,
  output logic                            mem_load,
  output logic                            mem_save,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [LINE_WORDS*BIT_WIDTH-1:0] mem_in,
  input  logic                            mem_ready,
  input  logic [LINE_WORDS*BIT_WIDTH-1:0] mem_out
);
  state_t                            state_q, state_d;
  logic                              write_q;
  logic [ADDR_W-1:0]                 addr_q;
  logic [LINE_WORDS*BIT_WIDTH-1:0]   wdata_q;
  logic                              accept;
  logic                              expired;

  lat_ram_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == IDLE),
    .enable  (state_q == RD_WAIT),
    .expired (expired)
  );

  // Outputs are gated by rst so nothing leaks during the reset cycle itself.
  assign req_ready   = (state_q == IDLE) && !rst;
  assign resp_valid  = (state_q == RESP) && !rst;
  assign mem_load    = (state_q == RD_WAIT) && !rst;
  assign mem_save    = (state_q == WR) && !rst;
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign accept      = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_write ? WR : RD_WAIT;
      RD_WAIT: if (mem_ready || expired) state_d = RESP;
      WR:      state_d = RESP;
      RESP:    state_d = write_q ? IDLE : DRAIN;
      // Wait out the RAM's trailing ready so it can't be mistaken for a later read's data.
      DRAIN:   if (!mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if ((state_q == IDLE) && accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == RD_WAIT) begin
        if (mem_ready) begin
          resp_rdata <= mem_out;
          resp_err   <= 1'b0;
        end else if (expired) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
      end
      if (state_q == WR)
        resp_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lat_ram_initiator.sv
// Randomized scoreboard bench for lat_ram_initiator with a two-cycle-latency RAM model.
module tb_lat_ram_initiator;
  localparam int BW = 16;
  localparam int TO = 7;
  localparam int LW = 4 * BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write;
  logic [15:0]   req_addr;
  logic [LW-1:0] req_wdata;
  logic          req_ready, resp_valid, resp_err;
  logic [LW-1:0] resp_rdata;
  logic          mem_load, mem_save;
  logic [15:0]   mem_address;
  logic [LW-1:0] mem_in;
  logic          mem_ready;
  logic [LW-1:0] mem_out;

  lat_ram_initiator #(.BIT_WIDTH(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_load(mem_load), .mem_save(mem_save), .mem_address(mem_address),
    .mem_in(mem_in), .mem_ready(mem_ready), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // RAM environment: load sampled at one edge, data and ready appear after the next.
  logic [LW-1:0] ram [0:65535];
  logic          ram_dead = 1'b0;
  logic          s1 = 1'b0;
  logic [15:0]   a1 = '0;
  initial begin
    mem_ready = 1'b0;
    mem_out   = '0;
  end
  always @(posedge clk) begin
    s1        <= mem_load && !ram_dead;
    a1        <= mem_address;
    mem_ready <= s1;
    mem_out   <= s1 ? ram[a1] : '0;
    if (mem_save) ram[mem_address] <= mem_in;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            wr;
    bit            err;
    logic [LW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t exq[$];

  logic [LW-1:0] ref_mem [logic [15:0]];
  logic [LW-1:0] last_rdata = '0;
  logic [15:0]   cur_addr = '0;
  logic [LW-1:0] cur_wdata = '0;
  int            save_cnt = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic cmp(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [LW-1:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return '0;
  endfunction

  // Monitor: pops the scoreboard on each response and checks bus-level rules every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_load && mem_save) cmp("load_save_exclusive", 1, 0);
      if (mem_load || mem_save) cmp("mem_address", LW'(mem_address), LW'(cur_addr));
      if (mem_save) begin
        save_cnt++;
        cmp("mem_in", mem_in, cur_wdata);
      end
      if (req_ready && mem_ready) cmp("ready_while_mem_ready", 1, 0);
      if (resp_valid) begin
        if (exq.size() == 0) begin
          cmp("spurious_resp", 1, 0);
        end else begin
          exp_t e;
          e = exq.pop_front();
          cmp("resp_err", LW'(resp_err), LW'(e.err));
          cmp("resp_rdata", resp_rdata, e.data);
          cmp("resp_latency", LW'(cyc), LW'(e.cyc));
          if (e.wr) cmp("save_pulses", LW'(save_cnt), 1);
          save_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [15:0] a, input logic [LW-1:0] d,
                       input bit dead, input bit track);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!req_ready) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_wdata = {$urandom, $urandom};
      guard++;
      if (guard > 200) begin
        cmp("req_ready_timeout", 0, 1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ram_dead  = dead;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    cur_addr  = a;
    cur_wdata = d;
    e.wr = w;
    if (w) begin
      e.err = 1'b0;
      e.data = last_rdata;
      e.cyc = cyc + 2;
      ref_mem[a] = d;
    end else if (dead) begin
      e.err = 1'b1;
      e.data = '0;
      e.cyc = cyc + 1 + TO + 1;
    end else begin
      e.err = 1'b0;
      e.data = ref_read(a);
      e.cyc = cyc + 4;
    end
    if (track) begin
      if (!w) last_rdata = e.data;
      exq.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_req_ready"}, LW'(req_ready), 0);
    cmp({tag, "_resp_valid"}, LW'(resp_valid), 0);
    cmp({tag, "_resp_err"}, LW'(resp_err), 0);
    cmp({tag, "_resp_rdata"}, resp_rdata, 0);
    cmp({tag, "_mem_load"}, LW'(mem_load), 0);
    cmp({tag, "_mem_save"}, LW'(mem_save), 0);
    cmp({tag, "_mem_address"}, LW'(mem_address), 0);
    cmp({tag, "_mem_in"}, mem_in, 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    cmp("drain_pending", LW'(exq.size()), 0);
  endtask

  initial begin
    logic [LW-1:0] rnd;
    logic [15:0]   addrs [5];
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    ram[16'h0020] = {4{16'd9}};
    ref_mem[16'h0020] = {4{16'd9}};
    rnd = {$urandom, $urandom};
    ram[16'h0030] = rnd;
    ref_mem[16'h0030] = rnd;
    addrs[0] = 16'h0010; addrs[1] = 16'h0020; addrs[2] = 16'h0030;
    addrs[3] = 16'h0040; addrs[4] = 16'h1230;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed: write, nominal read, timed-out read, back-to-back reads.
    issue(1'b1, 16'h0010, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b1);
    issue(1'b0, 16'h0010, '0, 1'b0, 1'b1);
    issue(1'b0, 16'h0040, '0, 1'b1, 1'b1);
    issue(1'b0, 16'h0010, '0, 1'b0, 1'b1);
    issue(1'b0, 16'h0020, '0, 1'b0, 1'b1);
    drain();

    // Reset while a read is in RD_WAIT: aborted without response.
    issue(1'b0, 16'h0030, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    last_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 16'h0030, '0, 1'b0, 1'b1);
    drain();

    for (int n = 0; n < 150; n++) begin
      bit w;
      bit dead;
      w = ($urandom_range(0, 9) < 4);
      dead = !w && ($urandom_range(0, 7) == 0);
      issue(w, addrs[$urandom_range(0, 4)], {$urandom, $urandom}, dead, 1'b1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
